// File: rtl/masked_sbox_seq_ctrl.sv
// masked_sbox_seq_ctrl
// Sequencing wrapper around one non-pipelined masked S-box core (for example
// an HPC2 gadget network). It holds the input shares steady for the core and
// clock-enables the core only in cycles where fresh randomness is available.
// After LATENCY enabled cycles it registers the result shares and presents
// them with a valid/ready handshake.
// Optional build macro: SBOX_CTRL_FLUSH_EN. When it is defined, the held input
// shares are cleared at the edge that captures the result. This keeps stale
// shares away from the core between transactions.

module masked_sbox_seq_ctrl #(
  parameter int SECURITY_ORDER = 1,
  parameter int WIDTH          = 4,
  parameter int LATENCY        = 13,
  parameter int FRESH_WIDTH    = 17
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [(SECURITY_ORDER+1)*WIDTH-1:0]   in_shares,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [(SECURITY_ORDER+1)*WIDTH-1:0]   out_shares,
  output logic [(SECURITY_ORDER+1)*WIDTH-1:0]   core_in,
  input  logic [(SECURITY_ORDER+1)*WIDTH-1:0]   core_out,
  output logic                                  core_en,
  output logic [FRESH_WIDTH-1:0]                core_rnd,
  input  logic [FRESH_WIDTH-1:0]                rnd_in,
  input  logic                                  rnd_valid,
  output logic                                  rnd_ready,
  output logic                                  synch
);

  localparam int SHARE_BITS = (SECURITY_ORDER + 1) * WIDTH;
  localparam int CNT_W      = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY < 1) ? 0 : LATENCY - 1);

  // A core that needs zero cycles has no meaning here, so refuse to build one.
  if (LATENCY < 1) begin : g_latency_check
    $error("masked_sbox_seq_ctrl: LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SHARE_BITS-1:0] in_reg_q, in_reg_d;
  logic [SHARE_BITS-1:0] out_shares_q, out_shares_d;
  logic                  synch_q, synch_d;

  // Next-state logic for the FSM and the datapath, plus the handshake and core-enable outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_reg_d     = in_reg_q;
    out_shares_d = out_shares_q;
    synch_d      = 1'b0;
    in_ready     = 1'b0;
    core_en      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in_reg_d = in_shares;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // The core advances only when fresh randomness is present. A stall just freezes the count.
        core_en = rnd_valid;
        if (rnd_valid) begin
          if (cnt_q == CNT_LAST) begin
            out_shares_d = core_out;
            synch_d      = 1'b1;
            cnt_d        = '0;
            state_d      = DONE;
`ifdef SBOX_CTRL_FLUSH_EN
            in_reg_d     = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        // The result is consumed here. A new input may be taken in the same edge.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            in_reg_d = in_shares;
            cnt_d    = '0;
            state_d  = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, with synchronous reset that discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      in_reg_q     <= '0;
      out_shares_q <= '0;
      synch_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_reg_q     <= in_reg_d;
      out_shares_q <= out_shares_d;
      synch_q      <= synch_d;
    end
  end

  assign out_valid  = (state_q == DONE);
  assign out_shares = out_shares_q;
  assign synch      = synch_q;
  assign core_in    = in_reg_q;
  assign core_rnd   = rnd_in & {FRESH_WIDTH{core_en}};
  assign rnd_ready  = core_en;

endmodule

// File: tb/tb_masked_sbox_seq_ctrl.sv
// Self-checking bench for masked_sbox_seq_ctrl. It uses two shares of 4 bits
// and a 13-cycle core model. The core model computes the SKINNY-64 S-box of
// the share XOR, re-masked with 0x5. It produces the correct value only in
// the enabled cycle in which the 13th cycle ends.
// The bench checks that the core input is flushed when SBOX_CTRL_FLUSH_EN is defined.

module tb_masked_sbox_seq_ctrl;

`ifdef SBOX_CTRL_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif
  localparam int LAT = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_shares;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_shares;
  logic [7:0]  core_in;
  logic [7:0]  core_out;
  logic        core_en;
  logic [16:0] core_rnd;
  logic [16:0] rnd_in;
  logic        rnd_valid;
  logic        rnd_ready;
  logic        synch;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [3:0] core_cnt;

  masked_sbox_seq_ctrl #(
    .SECURITY_ORDER(1), .WIDTH(4), .LATENCY(LAT), .FRESH_WIDTH(17)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_shares(in_shares),
    .out_valid(out_valid), .out_ready(out_ready), .out_shares(out_shares),
    .core_in(core_in), .core_out(core_out), .core_en(core_en), .core_rnd(core_rnd),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .synch(synch)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC; 4'h1: sbox = 4'h6; 4'h2: sbox = 4'h9; 4'h3: sbox = 4'h0;
      4'h4: sbox = 4'h1; 4'h5: sbox = 4'hA; 4'h6: sbox = 4'h2; 4'h7: sbox = 4'hB;
      4'h8: sbox = 4'h3; 4'h9: sbox = 4'h8; 4'hA: sbox = 4'h5; 4'hB: sbox = 4'hD;
      4'hC: sbox = 4'h4; 4'hD: sbox = 4'hE; 4'hE: sbox = 4'h7; default: sbox = 4'hF;
    endcase
  endfunction

  function automatic logic [7:0] model(input logic [7:0] sh);
    model = {4'h5, sbox(sh[3:0] ^ sh[7:4]) ^ 4'h5};
  endfunction

  // The core model counts its own enabled cycles since the last accept.
  always_ff @(posedge clk) begin
    if (rst || (in_valid && in_ready)) core_cnt <= 4'd0;
    else if (core_en) core_cnt <= core_cnt + 4'd1;
  end

  // The core gives a wrong value except in its final enabled cycle.
  always_comb begin
    core_out = {4'h0, ~sbox(core_in[3:0] ^ core_in[7:4])};
    if (core_en && (core_cnt == 4'(LAT - 1))) core_out = model(core_in);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Called at a falling edge. It offers one input and returns at the falling edge after the accept edge.
  task automatic send(input logic [7:0] sh, output bit ok);
    exp_q.push_back(model(sh));
    in_shares = sh;
    in_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Supplies randomness with an optional stall window and waits for out_valid.
  task automatic wait_out(input int stall_from, input int stall_len, input logic [7:0] exp_cin,
                          output int cyc, output int ens, output bit rnd_bad,
                          output bit cin_bad, output bit to);
    cyc = 0; ens = 0; rnd_bad = 1'b0; cin_bad = 1'b0; to = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      rnd_valid = !(c >= stall_from && c < stall_from + stall_len);
      rnd_in    = 17'($urandom());
      #1;
      if (out_valid) begin cyc = c; to = 1'b0; break; end
      if (core_en) ens++;
      if (core_rnd !== (core_en ? rnd_in : 17'd0)) rnd_bad = 1'b1;
      if (rnd_ready !== core_en) rnd_bad = 1'b1;
      if (core_in !== exp_cin) cin_bad = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rnd_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (core_en !== 1'b0) begin n_err++; $display("[TB] FAIL reset_core_en: got %b want 0", core_en); end
    n_vec++; if (out_shares !== 8'h00) begin n_err++; $display("[TB] FAIL reset_out_shares: got %h want 00", out_shares); end
    n_vec++; if (synch !== 1'b0) begin n_err++; $display("[TB] FAIL reset_synch: got %b want 0", synch); end
    rnd_valid = 1'b0;
  endtask

  task automatic test_single;
    bit ok, rb, cb, to; int cyc, ens; logic [7:0] e;
    @(negedge clk);
    send(8'h33, ok);
    wait_out(0, 0, 8'h33, cyc, ens, rb, cb, to);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_vec++; if (!ok || to) begin n_err++; $display("[TB] FAIL single_handshake: accepted %b timeout %b", ok, to); end
    n_vec++; if (cyc !== LAT + 1) begin n_err++; $display("[TB] FAIL single_latency: got %0d want %0d", cyc, LAT + 1); end
    n_vec++; if (ens !== LAT) begin n_err++; $display("[TB] FAIL single_core_en_cycles: got %0d want %0d", ens, LAT); end
    n_vec++; if (rb) begin n_err++; $display("[TB] FAIL single_rnd_gating: got bad want clean"); end
    n_vec++; if (cb) begin n_err++; $display("[TB] FAIL single_core_in_hold: got changed want 33"); end
    n_vec++; if (synch !== 1'b1) begin n_err++; $display("[TB] FAIL single_synch: got %b want 1", synch); end
    n_vec++; if (out_shares !== e) begin n_err++; $display("[TB] FAIL single_result: got %h want %h", out_shares, e); end
    n_vec++; if ((out_shares[3:0] ^ out_shares[7:4]) !== 4'hC) begin n_err++; $display("[TB] FAIL single_unmasked: got %h want c", out_shares[3:0] ^ out_shares[7:4]); end
    n_vec++; if (core_in !== (FLUSH ? 8'h00 : 8'h33)) begin n_err++; $display("[TB] FAIL single_core_in_after: got %h want %h", core_in, FLUSH ? 8'h00 : 8'h33); end
    out_ready = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (out_valid !== 1'b0 || synch !== 1'b0) begin n_err++; $display("[TB] FAIL single_release: got valid %b synch %b want 0 0", out_valid, synch); end
    out_ready = 1'b0;
  endtask

  task automatic test_stall;
    bit ok, rb, cb, to; int cyc, ens; logic [7:0] e;
    @(negedge clk);
    send(8'h33, ok);
    wait_out(5, 3, 8'h33, cyc, ens, rb, cb, to);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_vec++; if (!ok || to) begin n_err++; $display("[TB] FAIL stall_handshake: accepted %b timeout %b", ok, to); end
    n_vec++; if (cyc !== LAT + 4) begin n_err++; $display("[TB] FAIL stall_latency: got %0d want %0d", cyc, LAT + 4); end
    n_vec++; if (ens !== LAT) begin n_err++; $display("[TB] FAIL stall_core_en_cycles: got %0d want %0d", ens, LAT); end
    n_vec++; if (rb) begin n_err++; $display("[TB] FAIL stall_rnd_gating: got bad want clean"); end
    n_vec++; if (out_shares !== e) begin n_err++; $display("[TB] FAIL stall_result: got %h want %h", out_shares, e); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok, rb, cb, to; int cyc, ens, pulses; logic [7:0] e;
    @(negedge clk);
    send(8'hA6, ok);
    wait_out(0, 0, 8'hA6, cyc, ens, rb, cb, to);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_vec++; if (to || out_shares !== e) begin n_err++; $display("[TB] FAIL bp_result: got %h want %h", out_shares, e); end
    pulses = synch ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rnd_valid = 1'b1;
      #1;
      if (synch) pulses++;
      n_vec++; if (out_valid !== 1'b1 || out_shares !== e) begin n_err++; $display("[TB] FAIL bp_hold: got valid %b shares %h want 1 %h", out_valid, out_shares, e); end
      n_vec++; if (in_ready !== 1'b0 || rnd_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_ready: got in_ready %b rnd_ready %b want 0 0", in_ready, rnd_ready); end
    end
    n_vec++; if (pulses !== 1) begin n_err++; $display("[TB] FAIL bp_synch_count: got %0d want 1", pulses); end
    rnd_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_in_ready_follow: got %b want 1", in_ready); end
    @(negedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit ok, rb, cb, to; int cyc, ens; logic [7:0] e;
    @(negedge clk);
    send(8'h01, ok);
    wait_out(0, 0, 8'h01, cyc, ens, rb, cb, to);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_vec++; if (to || out_shares !== e || (out_shares[3:0] ^ out_shares[7:4]) !== 4'h6) begin n_err++; $display("[TB] FAIL b2b_first: got %h want %h", out_shares, e); end
    out_ready = 1'b1; in_valid = 1'b1; in_shares = 8'h57;
    exp_q.push_back(model(8'h57));
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    wait_out(0, 0, 8'h57, cyc, ens, rb, cb, to);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_vec++; if (to || cyc !== LAT + 1) begin n_err++; $display("[TB] FAIL b2b_gap: got %0d want %0d", cyc, LAT + 1); end
    n_vec++; if (cb) begin n_err++; $display("[TB] FAIL b2b_core_in: got changed want 57"); end
    n_vec++; if (out_shares !== e || (out_shares[3:0] ^ out_shares[7:4]) !== 4'h9) begin n_err++; $display("[TB] FAIL b2b_second: got %h want %h", out_shares, e); end
    n_vec++; if (core_in !== (FLUSH ? 8'h00 : 8'h57)) begin n_err++; $display("[TB] FAIL b2b_core_in_after: got %h want %h", core_in, FLUSH ? 8'h00 : 8'h57); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset;
    bit ok, rb, cb, to; int cyc, ens, seen; logic [7:0] e;
    @(negedge clk);
    send(8'h3C, ok);
    for (int c = 1; c <= 6; c++) begin
      rnd_valid = 1'b1;
      rnd_in = 17'($urandom());
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    #1;
    n_vec++; if (in_ready !== 1'b1 || core_en !== 1'b0 || rnd_ready !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_idle: got in_ready %b core_en %b rnd_ready %b want 1 0 0", in_ready, core_en, rnd_ready); end
    n_vec++; if (core_in !== 8'h00) begin n_err++; $display("[TB] FAIL midrst_core_in: got %h want 00", core_in); end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (out_valid || synch) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("[TB] FAIL midrst_no_output: got %0d want 0", seen); end
    rnd_valid = 1'b0;
    @(negedge clk);
    send(8'h47, ok);
    wait_out(0, 0, 8'h47, cyc, ens, rb, cb, to);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_vec++; if (to || cyc !== LAT + 1 || out_shares !== e) begin n_err++; $display("[TB] FAIL midrst_next: got %h at %0d want %h at %0d", out_shares, cyc, e, LAT + 1); end
    n_vec++; if (core_in !== (FLUSH ? 8'h00 : 8'h47)) begin n_err++; $display("[TB] FAIL midrst_core_in_after: got %h want %h", core_in, FLUSH ? 8'h00 : 8'h47); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_shares = 8'h00; out_ready = 1'b0;
    rnd_valid = 1'b0; rnd_in = 17'd0;
    test_reset();
    test_single();
    test_stall();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/masked_sbox_seq_ctrl.md
Name: masked_sbox_seq_ctrl

Overview:
- Parametrised sequencing wrapper for non-pipelined masked S-box cores such as the HPC2 gadget networks.
- Latency, share count, data width and randomness width are parameters.
- Adds a valid/ready handshake on input and output, a randomness-stall interface, and a per-transaction clock enable to the core.
- Sits between the round datapath and one masked S-box core instance.

Parameters:
SECURITY_ORDER, 1, masking order d; the number of shares is d+1.
WIDTH, 4, bits per share.
LATENCY, 13, enabled core cycles required for a valid result; must be >=1, and 0 is an elaboration error.
FRESH_WIDTH, 17, fresh random bits consumed by the core per enabled cycle.

Ports:
clk  in  1  single clock.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  input shares valid.
in_ready  out  1  block can accept input.
in_shares  in  (d+1)*WIDTH  input shares; share i occupies bits [i*WIDTH +: WIDTH].
out_valid  out  1  result shares valid.
out_ready  in  1  consumer accepts the result.
out_shares  out  (d+1)*WIDTH  registered result shares.
core_in  out  (d+1)*WIDTH  held input to the core.
core_out  in  (d+1)*WIDTH  core output shares.
core_en  out  1  clock enable / gate for core registers.
core_rnd  out  FRESH_WIDTH  randomness to the core; equals rnd_in AND core_en, otherwise 0.
rnd_in  in  FRESH_WIDTH  fresh randomness.
rnd_valid  in  1  rnd_in valid this cycle.
rnd_ready  out  1  rnd_in consumed; equals core_en.
synch  out  1  one-cycle pulse in the first cycle out_valid is high for a transaction.

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, cnt=0, in_reg=0, out_shares=0, out_valid=0, core_en=0, synch=0, in_ready=1 (in the cycle after reset).
- State IDLE:
  - in_ready=1.
  - An accept (in_valid&in_ready) at edge T loads in_reg and sets cnt=0, state=RUN.
- State RUN:
  - in_ready=0.
  - core_en = rnd_valid.
  - On an enabled cycle, cnt increments.
  - If rnd_valid=0, core_en=0 and cnt holds; this is a stall with no limit on length.
  - The enabled cycle with cnt==LATENCY-1 captures core_out into out_shares at that edge; state becomes DONE and out_valid becomes 1.
- State DONE:
  - out_valid=1; out_shares stable until the handshake; core_en=0.
  - in_ready = out_ready.
  - out_ready=1 and in_valid=0: go to IDLE, out_valid=0.
  - out_ready=1 and in_valid=1: accept new input in the same edge and go to RUN (back-to-back).
- Timing with no stalls: accept at edge T; core_en high for cycles T+1..T+LATENCY; out_valid first high in cycle T+LATENCY+1, with synch high only in that cycle.
- Core input: core_in = in_reg, constant for the whole RUN phase.
- Counter: cnt width is clog2(LATENCY+1); it never exceeds LATENCY-1, and there is no wrap.
- LATENCY=1: RUN lasts exactly one enabled cycle.
- Reset mid-operation: aborts immediately with reset values; the partial result is discarded and synch is not pulsed.
- rnd_valid outside RUN: ignored; rnd_ready=0.
- The block does not recombine shares; all share handling is share-wise only.

Optional Feature:
Macro SBOX_CTRL_FLUSH_EN.
- Defined:
  - in_reg is cleared to 0 at the edge that captures the result.
  - In that same edge, cnt, out_shares and the handshake behave as normal.
  - core_in is therefore 0 in IDLE and DONE, so no stale shares reach the core between transactions.
- Undefined: in_reg keeps the last accepted shares until the next accept.
- Latency and handshake timing are identical in both builds.

Test Plan:
Bench setup for all scenarios: d=1, WIDTH=4, LATENCY=13, core model = SKINNY-64 S-box on the XOR of the shares, re-masked with fixed mask 0x5.
1. Reset: rst=1 for 2 cycles mid-idle -> out_valid=0, in_ready=1, core_en=0, out_shares=0x00.
2. Single transaction: shares 0x3/0x3 (value 0x0), rnd_valid=1, accept at T -> core_en high for exactly 13 cycles; out_valid and synch at T+14; out_shares XOR = 0xC.
3. Randomness stall: as 2, with rnd_valid=0 for 3 cycles at T+5..T+7 -> core_en low in those cycles, out_valid at T+17, result 0xC.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid held, out_shares unchanged, in_ready=0, synch pulses once.
5. Back-to-back: input 0x1 then 0x2, with in_valid=1 and out_ready=1 in DONE -> second accept in the same cycle; out_valid low 13 cycles; results 0x6 then 0x9.
6. Mid-run reset: rst at T+7 -> no out_valid, no synch; the next transaction gives the correct result. With SBOX_CTRL_FLUSH_EN, core_in=0x00 after each capture.
